// File: rtl/link_monitor_if.sv
// rtl/link_monitor_if.sv - link_monitor signal bundle between PMD/descrambler side and supervisor
interface link_monitor_if;
    logic       signal_status;
    logic       locked;
    logic       test_mode_req;
    logic       descr_enable;
    logic       test_mode;
    logic       link_status;
    logic [3:0] retries;

    modport master (
        output signal_status, locked, test_mode_req,
        input  descr_enable, test_mode, link_status, retries
    );

    modport slave (
        input  signal_status, locked, test_mode_req,
        output descr_enable, test_mode, link_status, retries
    );
endinterface

// File: rtl/link_monitor.sv
// rtl/link_monitor.sv - receive-side link supervisor: gates the descrambler, retries on lock timeout, qualifies link
module link_monitor #(
    parameter logic [15:0] LOCK_TIMEOUT          = 16'd62500,
    parameter logic [15:0] STABILIZE_CYCLES      = 16'd50000,
    parameter logic [15:0] TEST_STABILIZE_CYCLES = 16'd625,
    parameter logic [15:0] FLUSH_CYCLES          = 16'd16
) (
    input  logic          clk,
    input  logic          rst,
    link_monitor_if.slave lnk
);
    typedef enum logic [2:0] {
        DOWN      = 3'd0,
        ACQUIRE   = 3'd1,
        STABILIZE = 3'd2,
        UP        = 3'd3,
        FLUSH     = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic        test_mode_q;
    logic [3:0]  retries_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DOWN;
            timer       <= 16'd0;
            test_mode_q <= 1'b0;
            retries_q   <= 4'd0;
        end else if (state != FLUSH && !lnk.signal_status) begin
            // loss of signal preempts everything except an in-progress flush
            state <= DOWN;
            timer <= LOCK_TIMEOUT - 16'd1;
        end else begin
            case (state)
                DOWN: begin
                    state       <= ACQUIRE;
                    timer       <= LOCK_TIMEOUT - 16'd1;
                    test_mode_q <= lnk.test_mode_req;
                end
                ACQUIRE: begin
                    if (lnk.locked) begin
                        state <= STABILIZE;
                        timer <= test_mode_q ? (TEST_STABILIZE_CYCLES - 16'd1)
                                             : (STABILIZE_CYCLES - 16'd1);
                    end else if (timer == 16'd0) begin
                        state <= FLUSH;
                        timer <= FLUSH_CYCLES - 16'd1;
                        if (retries_q != 4'd15)
                            retries_q <= retries_q + 4'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                STABILIZE: begin
                    if (!lnk.locked) begin
                        state <= ACQUIRE;
                        timer <= LOCK_TIMEOUT - 16'd1;
                    end else if (timer == 16'd0) begin
                        state     <= UP;
                        retries_q <= 4'd0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                UP: begin
                    if (!lnk.locked) begin
                        state <= ACQUIRE;
                        timer <= LOCK_TIMEOUT - 16'd1;
                    end
                end
                FLUSH: begin
                    if (timer == 16'd0) begin
                        state <= lnk.signal_status ? ACQUIRE : DOWN;
                        timer <= LOCK_TIMEOUT - 16'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: begin
                    state <= DOWN;
                    timer <= LOCK_TIMEOUT - 16'd1;
                end
            endcase
        end
    end

    // outputs decode straight from the state register, so they cannot glitch
    assign lnk.descr_enable = (state == ACQUIRE) || (state == STABILIZE) || (state == UP);
    assign lnk.link_status  = (state == UP);
    assign lnk.test_mode    = test_mode_q;
    assign lnk.retries      = retries_q;
endmodule

// File: tb/tb_link_monitor.sv
// tb/tb_link_monitor.sv - directed scoreboard bench for link_monitor
module tb_link_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [6:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    link_monitor_if lnk();

    link_monitor #(
        .LOCK_TIMEOUT          (16'd100),
        .STABILIZE_CYCLES      (16'd50000),
        .TEST_STABILIZE_CYCLES (16'd625),
        .FLUSH_CYCLES          (16'd16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lnk (lnk)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // expectation goes into the scoreboard with the stimulus, comes out when the DUT is sampled
    task automatic step(input int n, input string tag, input bit de, input bit tm,
                        input bit ls, input logic [3:0] rt);
        logic [6:0] obs;
        logic [6:0] exp_v;
        string      t;
        exp_q.push_back({de, tm, ls, rt});
        tag_q.push_back(tag);
        cyc(n);
        obs = {lnk.descr_enable, lnk.test_mode, lnk.link_status, lnk.retries};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%b required=entry", obs);
        end else begin
            exp_v = exp_q.pop_front();
            t     = tag_q.pop_front();
            assert (obs === exp_v) else begin
                fails++;
                $error("FAIL %s observed de/tm/ls/rt=%b required=%b", t, obs, exp_v);
            end
        end
    endtask

    initial begin
        lnk.signal_status = 1'b0;
        lnk.locked        = 1'b0;
        lnk.test_mode_req = 1'b0;

        // reset and normal bring-up with full stabilize count
        cyc(2);
        step(0, "reset_state", 0, 0, 0, 4'd0);
        rst = 1'b0;
        step(2, "down_idle", 0, 0, 0, 4'd0);
        lnk.signal_status = 1'b1;
        step(1, "acquire_entry", 1, 0, 0, 4'd0);
        step(9, "acquire_wait", 1, 0, 0, 4'd0);
        lnk.locked = 1'b1;
        step(1, "stabilize_entry", 1, 0, 0, 4'd0);
        step(49999, "stabilize_last", 1, 0, 0, 4'd0);
        step(1, "up_after_s", 1, 0, 1, 4'd0);

        // loss of signal in UP
        lnk.signal_status = 1'b0;
        step(1, "up_sigdrop", 0, 0, 0, 4'd0);

        // lock timeout/flush cycling with saturating retries
        lnk.locked        = 1'b0;
        lnk.signal_status = 1'b1;
        step(1, "acq_start", 1, 0, 0, 4'd0);
        for (int i = 1; i <= 16; i++) begin
            step(99, $sformatf("acq_end_%0d", i), 1, 0, 0, 4'((i - 1) > 15 ? 15 : (i - 1)));
            step(1, $sformatf("flush_start_%0d", i), 0, 0, 0, 4'(i > 15 ? 15 : i));
            step(15, $sformatf("flush_end_%0d", i), 0, 0, 0, 4'(i > 15 ? 15 : i));
            step(1, $sformatf("reacq_%0d", i), 1, 0, 0, 4'(i > 15 ? 15 : i));
        end

        // brief signal drop inside FLUSH must not shorten it
        step(99, "acq_pre_glitch", 1, 0, 0, 4'd15);
        step(1, "flush_glitch_in", 0, 0, 0, 4'd15);
        lnk.signal_status = 1'b0;
        cyc(3);
        lnk.signal_status = 1'b1;
        step(12, "flush_glitch_hold", 0, 0, 0, 4'd15);
        step(1, "flush_glitch_reacq", 1, 0, 0, 4'd15);

        // signal held low through FLUSH ends in DOWN
        step(99, "acq_pre_drop", 1, 0, 0, 4'd15);
        step(1, "flush_drop_in", 0, 0, 0, 4'd15);
        lnk.signal_status = 1'b0;
        step(15, "flush_drop_hold", 0, 0, 0, 4'd15);
        step(1, "flush_to_down", 0, 0, 0, 4'd15);
        step(5, "down_after_flush", 0, 0, 0, 4'd15);

        // test mode latch, mid-stabilize unlock, short stabilize count
        lnk.test_mode_req = 1'b1;
        step(1, "down_ignores_req", 0, 0, 0, 4'd15);
        lnk.signal_status = 1'b1;
        step(1, "tm_latched", 1, 1, 0, 4'd15);
        lnk.locked = 1'b1;
        step(1, "tm_stab_entry", 1, 1, 0, 4'd15);
        step(619, "tm_stab_t5", 1, 1, 0, 4'd15);
        lnk.locked = 1'b0;
        step(1, "unlock_to_acq", 1, 1, 0, 4'd15);
        lnk.locked = 1'b1;
        step(1, "relock", 1, 1, 0, 4'd15);
        step(624, "relock_full_count", 1, 1, 0, 4'd15);
        step(1, "tm_up", 1, 1, 1, 4'd0);
        lnk.test_mode_req = 1'b0;
        step(1, "tm_req_toggle_a", 1, 1, 1, 4'd0);
        lnk.test_mode_req = 1'b1;
        step(1, "tm_req_toggle_b", 1, 1, 1, 4'd0);
        lnk.test_mode_req = 1'b0;
        step(2, "tm_req_toggle_c", 1, 1, 1, 4'd0);

        // simultaneous signal and lock loss in UP goes to DOWN, not ACQUIRE
        lnk.signal_status = 1'b0;
        lnk.locked        = 1'b0;
        step(1, "up_both_drop", 0, 1, 0, 4'd0);
        lnk.signal_status = 1'b1;
        step(1, "tm_relatch_0", 1, 0, 0, 4'd0);

        // async reset mid-stabilize with nonzero retries
        step(99, "pre_rst_acq", 1, 0, 0, 4'd0);
        step(1, "pre_rst_flush", 0, 0, 0, 4'd1);
        step(16, "pre_rst_reacq", 1, 0, 0, 4'd1);
        lnk.locked = 1'b1;
        step(1, "pre_rst_stab", 1, 0, 0, 4'd1);
        cyc(10);
        #2;
        rst = 1'b1;
        #1;
        step(0, "async_rst", 0, 0, 0, 4'd0);
        cyc(2);
        rst = 1'b0;
        step(1, "post_rst_acq", 1, 0, 0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/link_monitor.md
# link_monitor

Receive-side link supervisor for the 100BASE-TX PCS. It sits between the PMD signal-detect and the descrambler. It gates the descrambler through `descr_enable`, which drives the descrambler's `signal_status`, and it forwards `test_mode`. It watches the descrambler's `locked` output, flushes and retries the descrambler when lock is not acquired in time, and qualifies `link_status` only after lock has been held stable.

## Interface
Parameters:
- `LOCK_TIMEOUT`, 16'd62500: cycles allowed in ACQUIRE before a flush (500 us at 125 MHz).
- `STABILIZE_CYCLES`, 16'd50000: consecutive locked cycles required before link up (400 us).
- `TEST_STABILIZE_CYCLES`, 16'd625: replaces `STABILIZE_CYCLES` when test mode is latched.
- `FLUSH_CYCLES`, 16'd16: cycles `descr_enable` is held low during a flush.

Ports:
- `clk`  in  1  PCS clock (125 MHz).
- `rst`  in  1  reset; asynchronous, active-high.
- `signal_status`  in  1  PMD signal detect.
- `locked`  in  1  descrambler lock indication.
- `test_mode_req`  in  1  request for short test timers.
- `descr_enable`  out  1  drives descrambler `signal_status`.
- `test_mode`  out  1  drives descrambler `test_mode`.
- `link_status`  out  1  link qualified up.
- `retries`  out  4  saturating count of lock-timeout flushes.

## Operation
- Outputs are decoded from registered state: `descr_enable` = (state ∈ {ACQUIRE, STABILIZE, UP}); `link_status` = (state == UP).
- One 16-bit down-counter `timer`, loaded on state entry.
- Reset values: state DOWN, `timer` 0, `test_mode` 0, `retries` 0, so `descr_enable` 0 and `link_status` 0.
- Priority at every edge: `signal_status`=0 wins over all other transitions and moves any state to DOWN, except FLUSH, which always completes.
- DOWN:
  - On `signal_status`=1, go to ACQUIRE.
  - Load `timer`=`LOCK_TIMEOUT`-1.
  - Latch `test_mode`<=`test_mode_req`.
- ACQUIRE:
  - If `locked`=1, go to STABILIZE and load `timer` = (`test_mode` ? `TEST_STABILIZE_CYCLES` : `STABILIZE_CYCLES`) - 1.
  - Else if `timer`==0, go to FLUSH, load `timer`=`FLUSH_CYCLES`-1, and increment `retries` (saturate at 15).
  - Else decrement `timer`.
- STABILIZE:
  - If `locked`=0, go to ACQUIRE and reload `LOCK_TIMEOUT`-1.
  - Else if `timer`==0, go to UP.
  - Else decrement `timer`.
- UP:
  - If `locked`=0, go to ACQUIRE and reload `LOCK_TIMEOUT`-1.
  - `retries` is cleared on entry to UP.
- FLUSH:
  - `descr_enable`=0, which clears the descrambler LFSR and lock.
  - Decrement `timer`.
  - When `timer`==0: go to ACQUIRE (reload `LOCK_TIMEOUT`-1) if `signal_status`=1, else go to DOWN.
- `test_mode` changes only on the DOWN→ACQUIRE edge. `test_mode_req` changes at any other time are ignored until the next pass through DOWN.
- `rst` asserted in any state forces the reset values immediately, without waiting for a clock edge. Operation resumes from DOWN on the first edge after deassertion.

## Timing
- Input-to-output latency is 1 edge: an input sampled at edge k is reflected in outputs after edge k.
- ACQUIRE with `locked` never asserted lasts exactly `LOCK_TIMEOUT` cycles.
- FLUSH lasts exactly `FLUSH_CYCLES` cycles with `descr_enable` low.
- Let `locked` first be sampled 1 at edge k while in ACQUIRE. If `locked` stays 1, UP is entered at edge k+S, where S is the active stabilize count. `link_status` is high from edge k+S.
- When `locked` or `signal_status` drops in UP, `link_status` falls at the next edge. There are no glitches, because outputs come from the state register.
- When `signal_status`=0 and `locked`=0 occur in the same cycle in UP, the next state is DOWN.

## Test plan
- Reset then `signal_status`=1 with `locked` rising 10 cycles later, `TEST`=0, S=50000 → `descr_enable` high 1 cycle after `signal_status`; `link_status` high exactly 50000 cycles after `locked` is sampled; `retries`=0.
- `locked` held 0 with `LOCK_TIMEOUT`=100, `FLUSH_CYCLES`=16 → `descr_enable` pattern repeats as 100 high / 16 low; `retries` counts 1, 2, … and saturates at 15 after 15 flushes.
- `test_mode_req`=1 before `signal_status` rises → `test_mode`=1 and UP reached 625 cycles after lock. Toggling `test_mode_req` while in UP leaves `test_mode` unchanged.
- `locked` drops for 1 cycle at STABILIZE `timer`=5 → return to ACQUIRE; the full S count restarts on relock; `link_status` stays 0 throughout.
- UP then `signal_status`=0 → next edge `link_status`=0 and `descr_enable`=0. The same drop during FLUSH still completes all 16 flush cycles, then enters DOWN.
- `rst` pulsed asynchronously mid-STABILIZE, between clock edges → all outputs reach reset values before the next edge; `retries` reads 0.
